dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU MEM stage and a secondary DMA/loader master.
- Sits between the CPU's ram_* outputs and the data memory.
- CPU has priority by default. Fairness comes from a DMA starvation counter. A DMA locked-burst mode is capped by a burst limit.
- While the CPU loses arbitration, cpu_stall_o is raised and feeds the CTRL stall request.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- STARVE_MAX, 4, consecutive denied DMA cycles before DMA wins over CPU
- BURST_MAX, 16, max consecutive locked DMA grants before forced one-cycle release

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- cpu_re_i  in  1  CPU MEM read enable
- cpu_we_i  in  1  CPU MEM write enable
- cpu_addr_i  in  ADDR_W  CPU address
- cpu_wdata_i  in  DATA_W  CPU write data
- cpu_rdata_o  out  DATA_W  CPU read data, combinational
- cpu_stall_o  out  1  CPU access not served this cycle
- dma_req_i  in  1  DMA access request
- dma_we_i  in  1  DMA write (1) / read (0)
- dma_lock_i  in  1  DMA requests burst lock
- dma_addr_i  in  ADDR_W  DMA address
- dma_wdata_i  in  DATA_W  DMA write data
- dma_gnt_o  out  1  DMA access performed this cycle
- dma_rdata_o  out  DATA_W  registered DMA read data
- dma_rvalid_o  out  1  dma_rdata_o valid, one-cycle pulse
- ram_re_o  out  1  memory read enable
- ram_we_o  out  1  memory write enable
- ram_addr_o  out  ADDR_W  memory address
- ram_wdata_o  out  DATA_W  memory write data
- ram_rdata_i  in  DATA_W  memory read data, combinational

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low: rst=0 sampled at the clk rising edge.
- Reset values:
  - State goes to IDLE.
  - starve_cnt=0, burst_cnt=0.
  - dma_rdata_o=0, dma_rvalid_o=0.
  - While rst=0, all combinational outputs are forced to 0.
- Owner per cycle (combinational): CPU, DMA or none. cpu_req = cpu_re_i|cpu_we_i.
- IDLE state:
  - DMA owns if dma_req_i and (starve_cnt==STARVE_MAX or !cpu_req); otherwise CPU owns if cpu_req.
  - If DMA owns and dma_lock_i=1, next state is LOCK.
- LOCK state:
  - If dma_req_i=1, DMA owns regardless of cpu_req; burst_cnt increments per grant.
  - When a grant makes burst_cnt reach BURST_MAX, or dma_lock_i=0 at a grant, the next state is RELEASE (burst_cnt limit) or IDLE (lock dropped).
  - If dma_req_i=0, the cycle is arbitrated as IDLE with no DMA request; next state is IDLE.
- RELEASE state: lasts exactly one cycle. CPU owns if cpu_req; DMA is never granted. Next state is IDLE; burst_cnt clears.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, each cycle with dma_req_i=1 and no DMA grant.
  - Clears on a DMA grant or when dma_req_i=0.
  - Width is clog2(STARVE_MAX+1).
- CPU owns:
  - ram_* = cpu_* pass-through; cpu_rdata_o = ram_rdata_i.
  - cpu_stall_o=0; dma_gnt_o=0.
- DMA owns:
  - ram_re_o=!dma_we_i, ram_we_o=dma_we_i; ram_addr/wdata from the DMA port.
  - dma_gnt_o=1; cpu_rdata_o=0.
  - cpu_stall_o=cpu_req.
- No owner: ram_re_o=ram_we_o=0; address and write data are 0.
- DMA reads: the cycle after a granted read, dma_rdata_o = sampled ram_rdata_i and dma_rvalid_o=1. Latency is 1 cycle. Writes produce no rvalid.
- Stalled CPU: holds its request. The arbiter keeps no CPU state; the retry is served the next cycle it owns.
- cpu_re_i and cpu_we_i both high: passed through unchanged; the CPU never generates this.
- Reset mid-burst: the burst is abandoned. rvalid clears even if a read was granted the prior cycle.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cpu_stall_o (32) and stat_dma_xfer_o (32).
  - Counts cycles with cpu_stall_o=1 and DMA grants, respectively.
  - Saturating at 0xFFFFFFFF; cleared by reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all requests high -> every output 0; first cycle after release with only cpu_re_i=1 -> CPU served.
- CPU-only read: cpu_re_i=1, addr 0x10, ram_rdata_i=0x12345678 -> ram_re_o=1, ram_addr_o=0x10, cpu_rdata_o=0x12345678 same cycle, cpu_stall_o=0.
- Contention, STARVE_MAX=4: cpu_req and dma_req (unlocked) held high every cycle -> CPU wins cycles 0-3; DMA granted cycle 4 with cpu_stall_o=1; CPU wins cycles 5-8; DMA wins cycle 9.
- DMA read data: granted read at 0x40, ram_rdata_i=0xDEADBEEF -> next cycle dma_rdata_o=0xDEADBEEF, dma_rvalid_o=1 for one cycle.
- Locked burst, BURST_MAX=16, CPU requesting: 20 locked DMA reads -> dma_gnt_o for 16 cycles, cpu_stall_o=1 throughout; cycle 17 CPU served, dma_gnt_o=0; DMA re-granted per IDLE rules afterwards.
- Reset mid-burst: rst=0 on the 5th locked grant -> next cycle state IDLE, dma_rvalid_o=0, burst_cnt=0; CPU request after release served immediately.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a DMA/loader master.
// Optional cycle statistics are compiled in with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BURST_MAX  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic              dma_lock_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_rvalid_o,
  output logic              ram_re_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]       stat_cpu_stall_o,
  output logic [31:0]       stat_dma_xfer_o,
`endif
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BurstW  = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {StIdle, StLock, StRelease} state_e;

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [BurstW-1:0]   burst_q, burst_d, burst_inc;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                dma_rvalid_q, dma_rvalid_d;
  logic                cpu_req, cpu_own, dma_own, starve_hit;

  assign cpu_req    = cpu_re_i | cpu_we_i;
  assign starve_hit = (starve_q == StarveW'(STARVE_MAX));

  // Owner selection; reset suppresses every grant.
  always_comb begin
    cpu_own = 1'b0;
    dma_own = 1'b0;
    unique case (state_q)
      StIdle: begin
        dma_own = dma_req_i & (starve_hit | ~cpu_req);
        cpu_own = ~dma_own & cpu_req;
      end
      StLock: begin
        dma_own = dma_req_i;
        cpu_own = ~dma_req_i & cpu_req;
      end
      StRelease: cpu_own = cpu_req;
      default: ;
    endcase
    if (!rst) begin
      cpu_own = 1'b0;
      dma_own = 1'b0;
    end
  end

  always_comb begin
    state_d   = StIdle;
    burst_d   = '0;
    burst_inc = burst_q + BurstW'(1);
    // The grant that opens a lock counts as the first beat of the burst.
    if (dma_own && (state_q == StLock || dma_lock_i)) begin
      if (burst_inc == BurstW'(BURST_MAX)) begin
        state_d = StRelease;
      end else if (dma_lock_i) begin
        state_d = StLock;
        burst_d = burst_inc;
      end
    end
    starve_d = '0;
    if (dma_req_i && !dma_own) begin
      starve_d = starve_hit ? starve_q : starve_q + StarveW'(1);
    end
    dma_rvalid_d = dma_own & ~dma_we_i;
    dma_rdata_d  = dma_rvalid_d ? ram_rdata_i : dma_rdata_q;
  end

  always_comb begin
    ram_re_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    cpu_rdata_o = '0;
    if (cpu_own) begin
      ram_re_o    = cpu_re_i;
      ram_we_o    = cpu_we_i;
      ram_addr_o  = cpu_addr_i;
      ram_wdata_o = cpu_wdata_i;
      cpu_rdata_o = ram_rdata_i;
    end else if (dma_own) begin
      ram_re_o    = ~dma_we_i;
      ram_we_o    = dma_we_i;
      ram_addr_o  = dma_addr_i;
      ram_wdata_o = dma_wdata_i;
    end
  end

  assign cpu_stall_o  = dma_own & cpu_req;
  assign dma_gnt_o    = dma_own;
  assign dma_rdata_o  = dma_rdata_q;
  assign dma_rvalid_o = dma_rvalid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      starve_q     <= '0;
      burst_q      <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      burst_q      <= burst_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d, stat_xfer_q, stat_xfer_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_xfer_d  = stat_xfer_q;
    if (cpu_stall_o && stat_stall_q != '1) stat_stall_d = stat_stall_q + 32'd1;
    if (dma_gnt_o && stat_xfer_q != '1)    stat_xfer_d  = stat_xfer_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_stall_q <= '0;
      stat_xfer_q  <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_xfer_q  <= stat_xfer_d;
    end
  end

  assign stat_cpu_stall_o = stat_stall_q;
  assign stat_dma_xfer_o  = stat_xfer_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;
  localparam int unsigned BMAX = 16;

  logic          clk, rst;
  logic          cpu_re_i, cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i, cpu_rdata_o;
  logic          cpu_stall_o;
  logic          dma_req_i, dma_we_i, dma_lock_i;
  logic [AW-1:0] dma_addr_i;
  logic [DW-1:0] dma_wdata_i, dma_rdata_o;
  logic          dma_gnt_o, dma_rvalid_o;
  logic          ram_re_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_re_i(cpu_re_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_lock_i(dma_lock_i),
    .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i), .dma_gnt_o(dma_gnt_o),
    .dma_rdata_o(dma_rdata_o), .dma_rvalid_o(dma_rvalid_o),
    .ram_re_o(ram_re_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = arbitrate normally, 1 = DMA holds a lock, 2 = forced release.
  int            m_mode = 0;
  int            m_starve = 0;
  int            m_beats = 0;
  int            m_owner = 0;  // 0 none, 1 cpu, 2 dma
  logic [DW-1:0] m_rdata = '0;
  logic          m_rvalid = 1'b0;
  logic          e_re, e_we, e_stall, e_gnt;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_cpu_rdata;

  function automatic void model_eval();
    bit creq;
    creq    = cpu_re_i || cpu_we_i;
    m_owner = 0;
    if (rst) begin
      if (m_mode == 1 && dma_req_i) m_owner = 2;
      else if (m_mode == 0 && dma_req_i && (m_starve == SMAX || !creq)) m_owner = 2;
      else if (creq) m_owner = 1;
    end
    e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_cpu_rdata = '0;
    if (m_owner == 1) begin
      e_re = cpu_re_i; e_we = cpu_we_i; e_addr = cpu_addr_i; e_wdata = cpu_wdata_i;
      e_cpu_rdata = ram_rdata_i;
    end else if (m_owner == 2) begin
      e_re = !dma_we_i; e_we = dma_we_i; e_addr = dma_addr_i; e_wdata = dma_wdata_i;
    end
    e_gnt   = (m_owner == 2);
    e_stall = (m_owner == 2) && creq;
  endfunction

  function automatic void model_clock();
    if (!rst) begin
      m_mode = 0; m_starve = 0; m_beats = 0; m_rdata = '0; m_rvalid = 0;
    end else begin
      m_rvalid = (m_owner == 2) && !dma_we_i;
      if (m_rvalid) m_rdata = ram_rdata_i;
      if (dma_req_i && m_owner != 2) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
      if (m_owner == 2 && (m_mode == 1 || dma_lock_i)) begin
        m_beats++;
        if (m_beats == BMAX) begin m_mode = 2; m_beats = 0; end
        else if (!dma_lock_i) begin m_mode = 0; m_beats = 0; end
        else m_mode = 1;
      end else begin
        m_mode = 0; m_beats = 0;
      end
    end
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic zero_inputs();
    cpu_re_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dma_req_i = 0; dma_we_i = 0; dma_lock_i = 0; dma_addr_i = '0; dma_wdata_i = '0;
    ram_rdata_i = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    logic [AW+3*DW+4:0] outv;
    zero_inputs();
    cpu_re_i = 1; dma_req_i = 1; dma_lock_i = 1;
    cpu_addr_i = 32'h0000_0123; dma_addr_i = 32'h0000_0456; ram_rdata_i = 32'hA5A5_A5A5;
    rst = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #4;
      outv = {ram_re_o, ram_we_o, ram_addr_o, ram_wdata_o, cpu_rdata_o, cpu_stall_o,
              dma_gnt_o, dma_rdata_o, dma_rvalid_o};
      checks++;
      if (outv !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: got %h expected 0", i, outv);
      end
      tick();
    end
    rst = 1; dma_req_i = 0; dma_lock_i = 0; cpu_addr_i = 32'h20;
    #4;
    checks++;
    if ({ram_re_o, ram_addr_o, cpu_stall_o, dma_gnt_o} !== {1'b1, 32'h20, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release_cpu: got re=%b addr=%h stall=%b gnt=%b expected 1 20 0 0",
               ram_re_o, ram_addr_o, cpu_stall_o, dma_gnt_o);
    end
    tick();
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_re_i = 1; cpu_addr_i = 32'h10; ram_rdata_i = 32'h1234_5678;
    #4;
    checks++;
    if (ram_re_o !== 1'b1) begin
      errors++; $display("FAIL cpu_read_re: got %b expected 1", ram_re_o);
    end
    checks++;
    if (ram_addr_o !== 32'h10) begin
      errors++; $display("FAIL cpu_read_addr: got %h expected 10", ram_addr_o);
    end
    checks++;
    if (cpu_rdata_o !== 32'h1234_5678) begin
      errors++; $display("FAIL cpu_read_data: got %h expected 12345678", cpu_rdata_o);
    end
    checks++;
    if (cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL cpu_read_stall: got %b expected 0", cpu_stall_o);
    end
    tick();
  endtask

  task automatic test_contention();
    bit exp_gnt;
    do_reset();
    cpu_re_i = 1; cpu_addr_i = 32'h0000_1000; dma_req_i = 1; dma_addr_i = 32'h0000_2000;
    for (int c = 0; c < 10; c++) begin
      exp_gnt = (c == 4 || c == 9);
      #4;
      checks++;
      if ({dma_gnt_o, cpu_stall_o} !== {exp_gnt, exp_gnt}) begin
        errors++;
        $display("FAIL contention cyc %0d: got gnt=%b stall=%b expected %b %b",
                 c, dma_gnt_o, cpu_stall_o, exp_gnt, exp_gnt);
      end
      checks++;
      if (ram_addr_o !== (exp_gnt ? 32'h2000 : 32'h1000)) begin
        errors++;
        $display("FAIL contention_addr cyc %0d: got %h", c, ram_addr_o);
      end
      tick();
    end
  endtask

  task automatic test_dma_read();
    do_reset();
    dma_req_i = 1; dma_addr_i = 32'h40; ram_rdata_i = 32'hDEAD_BEEF;
    #4;
    checks++;
    if ({dma_gnt_o, ram_re_o, ram_we_o, ram_addr_o, cpu_rdata_o} !==
        {1'b1, 1'b1, 1'b0, 32'h40, 32'h0}) begin
      errors++;
      $display("FAIL dma_read_bus: got gnt=%b re=%b we=%b addr=%h cpu_rdata=%h expected 1 1 0 40 0",
               dma_gnt_o, ram_re_o, ram_we_o, ram_addr_o, cpu_rdata_o);
    end
    tick();
    dma_req_i = 0; ram_rdata_i = 32'h0BAD_F00D;
    #4;
    checks++;
    if ({dma_rvalid_o, dma_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL dma_read_data: got rvalid=%b rdata=%h expected 1 deadbeef",
               dma_rvalid_o, dma_rdata_o);
    end
    tick();
    #4;
    checks++;
    if (dma_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL dma_rvalid_pulse: got %b expected 0", dma_rvalid_o);
    end
    tick();
  endtask

  task automatic test_locked_burst();
    bit exp_gnt;
    do_reset();
    cpu_re_i = 1; cpu_addr_i = 32'h100; dma_req_i = 1; dma_lock_i = 1; dma_addr_i = 32'h200;
    // Starvation opens the burst at cycle 4; 16 beats, one release cycle, then the
    // counter needs another four denied cycles before the next grant.
    for (int c = 0; c < 26; c++) begin
      exp_gnt = (c >= 4 && c <= 19) || c == 24 || c == 25;
      #4;
      checks++;
      if ({dma_gnt_o, cpu_stall_o} !== {exp_gnt, exp_gnt}) begin
        errors++;
        $display("FAIL locked_burst cyc %0d: got gnt=%b stall=%b expected %b %b",
                 c, dma_gnt_o, cpu_stall_o, exp_gnt, exp_gnt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    bit exp_gnt;
    do_reset();
    dma_req_i = 1; dma_lock_i = 1; dma_addr_i = 32'h300; ram_rdata_i = 32'h5555_AAAA;
    for (int c = 0; c < 4; c++) begin
      #4;
      checks++;
      if (dma_gnt_o !== 1'b1) begin
        errors++; $display("FAIL mid_burst_pre cyc %0d: got gnt=%b expected 1", c, dma_gnt_o);
      end
      tick();
    end
    rst = 0;
    #4;
    checks++;
    if (dma_gnt_o !== 1'b0) begin
      errors++; $display("FAIL mid_burst_rst_gnt: got %b expected 0", dma_gnt_o);
    end
    tick();
    rst = 1; cpu_re_i = 1; cpu_addr_i = 32'h44;
    #4;
    checks++;
    if ({dma_rvalid_o, dma_rdata_o, dma_gnt_o, cpu_stall_o, ram_re_o, ram_addr_o} !==
        {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h44}) begin
      errors++;
      $display("FAIL mid_burst_after: got rvalid=%b rdata=%h gnt=%b stall=%b re=%b addr=%h",
               dma_rvalid_o, dma_rdata_o, dma_gnt_o, cpu_stall_o, ram_re_o, ram_addr_o);
    end
    tick();
    // A fresh burst must run the full 16 beats, proving the beat count was cleared.
    cpu_re_i = 0;
    for (int c = 0; c < 18; c++) begin
      exp_gnt = (c != 16);
      #4;
      checks++;
      if (dma_gnt_o !== exp_gnt) begin
        errors++;
        $display("FAIL mid_burst_fresh cyc %0d: got gnt=%b expected %b", c, dma_gnt_o, exp_gnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int sel;
    bit phase_a;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      phase_a     = (n < 400);
      rst         = ($urandom_range(0, 79) != 0);
      sel         = $urandom_range(0, 3);
      cpu_re_i    = (sel == 1 || sel == 3);
      cpu_we_i    = (sel == 2);
      cpu_addr_i  = $urandom;
      cpu_wdata_i = $urandom;
      dma_req_i   = phase_a ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
      dma_lock_i  = phase_a ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 1) != 0);
      dma_we_i    = $urandom_range(0, 1);
      dma_addr_i  = $urandom;
      dma_wdata_i = $urandom;
      ram_rdata_i = $urandom;
      #4;
      model_eval();
      checks++;
      if ({dma_gnt_o, cpu_stall_o} !== {e_gnt, e_stall}) begin
        errors++;
        $display("FAIL rand_owner cyc %0d: got gnt=%b stall=%b expected %b %b",
                 n, dma_gnt_o, cpu_stall_o, e_gnt, e_stall);
      end
      checks++;
      if ({ram_re_o, ram_we_o, ram_addr_o, ram_wdata_o} !== {e_re, e_we, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL rand_ram cyc %0d: got %b %b %h %h expected %b %b %h %h", n, ram_re_o,
                 ram_we_o, ram_addr_o, ram_wdata_o, e_re, e_we, e_addr, e_wdata);
      end
      checks++;
      if (cpu_rdata_o !== e_cpu_rdata) begin
        errors++;
        $display("FAIL rand_cpu_rdata cyc %0d: got %h expected %h", n, cpu_rdata_o, e_cpu_rdata);
      end
      checks++;
      if ({dma_rvalid_o, dma_rdata_o} !== {m_rvalid, m_rdata}) begin
        errors++;
        $display("FAIL rand_dma_rdata cyc %0d: got %b %h expected %b %h",
                 n, dma_rvalid_o, dma_rdata_o, m_rvalid, m_rdata);
      end
      tick();
    end
  endtask

  initial begin
    zero_inputs();
    rst = 0;
    test_reset();
    test_cpu_read();
    test_contention();
    test_dma_read();
    test_locked_burst();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
